// File: rtl/gate_list_config_if.sv
// Bundle between the management side, gate_list_config and the gate control list RAM port A.
interface gate_list_config_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  logic              i_cfg_wr;
  logic              i_cfg_rd;
  logic [ADDR_W-1:0] iv_cfg_addr;
  logic [DATA_W-1:0] iv_cfg_wdata;
  logic [DATA_W-1:0] ov_cfg_rdata;
  logic              o_cfg_rdata_valid;
  logic              o_cfg_busy;
  logic              i_init_start;
  logic [DATA_W-1:0] iv_init_data;
  logic              o_init_done;
  logic [7:0]        ov_drop_cnt;
  logic [ADDR_W-1:0] ov_ram_addr;
  logic [DATA_W-1:0] ov_ram_wdata;
  logic              o_ram_wr;
  logic              o_ram_rd;
  logic [DATA_W-1:0] iv_ram_rdata;

  modport slave (
    input  i_cfg_wr, i_cfg_rd, iv_cfg_addr, iv_cfg_wdata, i_init_start, iv_init_data,
           iv_ram_rdata,
    output ov_cfg_rdata, o_cfg_rdata_valid, o_cfg_busy, o_init_done, ov_drop_cnt,
           ov_ram_addr, ov_ram_wdata, o_ram_wr, o_ram_rd
  );

  modport master (
    output i_cfg_wr, i_cfg_rd, iv_cfg_addr, iv_cfg_wdata, i_init_start, iv_init_data,
           iv_ram_rdata,
    input  ov_cfg_rdata, o_cfg_rdata_valid, o_cfg_busy, o_init_done, ov_drop_cnt,
           ov_ram_addr, ov_ram_wdata, o_ram_wr, o_ram_rd
  );
endinterface

// File: rtl/gate_list_config.sv
// Port-A writer for the gate control list RAM: single write, read-back and bulk init,
// with a saturating counter of requests that were ignored or lost to priority.
module gate_list_config #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned RAM_RD_LATENCY = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  gate_list_config_if.slave bus
);

  localparam int unsigned WAIT_W = (RAM_RD_LATENCY > 2) ? $clog2(RAM_RD_LATENCY) : 1;
  localparam int unsigned DROP_W = 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_DATA = 3'd4,
    INIT    = 3'd5
  } state_t;

  state_t              state, state_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic [ADDR_W-1:0]   ram_addr, addr_n;
  logic [DATA_W-1:0]   ram_wdata, wdata_n;
  logic                ram_wr, wr_n;
  logic                ram_rd, rd_n;
  logic [DATA_W-1:0]   cfg_rdata, rdata_n;
  logic                rdata_valid, valid_n;
  logic                busy, busy_n;
  logic                init_done, done_n;
  logic [DROP_W-1:0]   drop_cnt, drop_n;
  logic [1:0]          req_cnt, drop_inc;
  logic [DROP_W:0]     drop_sum;

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_wr      <= 1'b0;
      ram_rd      <= 1'b0;
      cfg_rdata   <= '0;
      rdata_valid <= 1'b0;
      busy        <= 1'b0;
      init_done   <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      ram_addr    <= addr_n;
      ram_wdata   <= wdata_n;
      ram_wr      <= wr_n;
      ram_rd      <= rd_n;
      cfg_rdata   <= rdata_n;
      rdata_valid <= valid_n;
      busy        <= busy_n;
      init_done   <= done_n;
      drop_cnt    <= drop_n;
    end
  end

  // Next state and next registered output values
  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    addr_n  = ram_addr;
    wdata_n = ram_wdata;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    rdata_n = cfg_rdata;
    valid_n = 1'b0;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.i_init_start) begin
          state_n = INIT;
          wr_n    = 1'b1;
          addr_n  = '0;
          wdata_n = bus.iv_init_data;
        end else if (bus.i_cfg_wr) begin
          state_n = WR;
          wr_n    = 1'b1;
          addr_n  = bus.iv_cfg_addr;
          wdata_n = bus.iv_cfg_wdata;
        end else if (bus.i_cfg_rd) begin
          state_n = RD_REQ;
          rd_n    = 1'b1;
          addr_n  = bus.iv_cfg_addr;
        end
      end
      WR: state_n = IDLE;
      RD_REQ: begin
        if (RAM_RD_LATENCY > 1) begin
          state_n = RD_WAIT;
          wait_n  = WAIT_W'(RAM_RD_LATENCY - 2);
        end else begin
          state_n = RD_DATA;
        end
      end
      RD_WAIT: begin
        if (wait_cnt == '0) state_n = RD_DATA;
        else                wait_n  = wait_cnt - WAIT_W'(1);
      end
      RD_DATA: begin
        state_n = IDLE;
        rdata_n = bus.iv_ram_rdata;
        valid_n = 1'b1;
      end
      INIT: begin
        // Stop after the top entry so the sweep never wraps into a second pass
        if (ram_addr == LAST_ADDR) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          wr_n   = 1'b1;
          addr_n = ram_addr + ADDR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // In IDLE the winning request is not a drop; otherwise every request bit is
  always_comb begin
    req_cnt  = 2'(bus.i_cfg_wr) + 2'(bus.i_cfg_rd) + 2'(bus.i_init_start);
    drop_inc = ((state == IDLE) && (req_cnt != 2'd0)) ? (req_cnt - 2'd1) : req_cnt;
    drop_sum = (DROP_W+1)'(drop_cnt) + (DROP_W+1)'(drop_inc);
    drop_n   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  assign bus.ov_ram_addr       = ram_addr;
  assign bus.ov_ram_wdata      = ram_wdata;
  assign bus.o_ram_wr          = ram_wr;
  assign bus.o_ram_rd          = ram_rd;
  assign bus.ov_cfg_rdata      = cfg_rdata;
  assign bus.o_cfg_rdata_valid = rdata_valid;
  assign bus.o_cfg_busy        = busy;
  assign bus.o_init_done       = init_done;
  assign bus.ov_drop_cnt       = drop_cnt;

endmodule

// File: tb/tb_gate_list_config.sv
// Directed bench for gate_list_config with a two-stage-latency RAM model on port A.
module tb_gate_list_config;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  gate_list_config_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  gate_list_config #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_RD_LATENCY(2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_stage = '0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, both_cnt = 0;
  int init_wr_cnt = 0, init_err = 0;
  logic init_mon = 1'b0;
  logic [ADDR_W-1:0] init_exp = '0;
  logic [DATA_W-1:0] init_val = '0;

  // RAM port A model plus strobe monitors
  always @(posedge clk) begin
    if (bus.o_ram_wr) begin
      mem[bus.ov_ram_addr] <= bus.ov_ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.o_ram_rd) begin
      rd_stage <= mem[bus.ov_ram_addr];
      rd_cnt   <= rd_cnt + 1;
    end
    bus.iv_ram_rdata <= rd_stage;
    if (bus.o_init_done) done_cnt <= done_cnt + 1;
    if (bus.o_ram_wr && bus.o_ram_rd) both_cnt <= both_cnt + 1;
    if (init_mon && bus.o_ram_wr) begin
      if (bus.ov_ram_addr !== init_exp || bus.ov_ram_wdata !== init_val) init_err <= init_err + 1;
      init_exp    <= init_exp + ADDR_W'(1);
      init_wr_cnt <= init_wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.ov_ram_addr, bus.ov_ram_wdata, bus.o_ram_wr, bus.o_ram_rd,
                bus.ov_cfg_rdata, bus.o_cfg_rdata_valid, bus.o_cfg_busy,
                bus.o_init_done, bus.ov_drop_cnt});
  endfunction

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                         input string tag);
    int lat;
    bus.i_cfg_rd    = 1'b1;
    bus.iv_cfg_addr = a;
    tick();
    bus.i_cfg_rd = 1'b0;
    check({tag, "_strobe"}, 64'({bus.o_ram_rd, bus.o_ram_wr, bus.ov_ram_addr}),
          64'({1'b1, 1'b0, a}));
    lat = 1;
    while (!bus.o_cfg_rdata_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_valid_cycle"}, 64'(lat), 64'd4);
    check({tag, "_data"}, 64'(bus.ov_cfg_rdata), 64'(exp));
    tick();
    check({tag, "_pulse_hold"}, 64'({bus.o_cfg_rdata_valid, bus.o_cfg_busy, bus.ov_cfg_rdata}),
          64'({1'b0, 1'b0, exp}));
  endtask

  initial begin
    int cyc;
    int base;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    bus.i_cfg_wr     = 1'b0;
    bus.i_cfg_rd     = 1'b0;
    bus.iv_cfg_addr  = '0;
    bus.iv_cfg_wdata = '0;
    bus.i_init_start = 1'b0;
    bus.iv_init_data = '0;

    // Reset and idle
    repeat (3) tick();
    check("rst_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_outputs", outs(), 64'd0);
    check("idle_strobes", 64'(wr_cnt + rd_cnt), 64'd0);

    // Single write then read-back
    bus.i_cfg_wr = 1'b1; bus.iv_cfg_addr = 10'h005; bus.iv_cfg_wdata = 8'hA5;
    tick();
    bus.i_cfg_wr = 1'b0;
    check("wr_strobe", 64'({bus.o_ram_wr, bus.o_ram_rd, bus.ov_ram_addr, bus.ov_ram_wdata, bus.o_cfg_busy}),
          64'({1'b1, 1'b0, 10'h005, 8'hA5, 1'b1}));
    tick();
    check("wr_end", 64'({bus.o_ram_wr, bus.o_cfg_busy}), 64'd0);
    do_read(10'h005, 8'hA5, "rd005");

    // Write beats read in the same cycle
    bus.i_cfg_wr = 1'b1; bus.i_cfg_rd = 1'b1; bus.iv_cfg_addr = 10'h007; bus.iv_cfg_wdata = 8'h3C;
    tick();
    bus.i_cfg_wr = 1'b0; bus.i_cfg_rd = 1'b0;
    check("wr_rd_prio", 64'({bus.o_ram_wr, bus.o_ram_rd, bus.ov_ram_addr, bus.ov_ram_wdata}),
          64'({1'b1, 1'b0, 10'h007, 8'h3C}));
    check("wr_rd_drop", 64'(bus.ov_drop_cnt), 64'd1);
    tick();

    // Write held four cycles: accepted every other cycle
    base = wr_cnt;
    bus.i_cfg_wr = 1'b1; bus.iv_cfg_addr = 10'h008; bus.iv_cfg_wdata = 8'h11;
    repeat (4) tick();
    bus.i_cfg_wr = 1'b0;
    repeat (2) tick();
    check("held_wr_count", 64'(wr_cnt - base), 64'd2);
    check("held_wr_drop", 64'(bus.ov_drop_cnt), 64'd3);
    do_read(10'h007, 8'h3C, "rd007");

    // Bulk init with FF
    init_val = 8'hFF; init_exp = '0; init_wr_cnt = 0; init_mon = 1'b1;
    base = done_cnt;
    bus.i_init_start = 1'b1; bus.iv_init_data = 8'hFF;
    tick();
    bus.i_init_start = 1'b0; bus.iv_init_data = 8'h00;
    check("init_first", 64'({bus.o_ram_wr, bus.o_ram_rd, bus.ov_ram_addr, bus.ov_ram_wdata, bus.o_cfg_busy}),
          64'({1'b1, 1'b0, 10'h000, 8'hFF, 1'b1}));
    cyc = 1;
    while (!bus.o_init_done && cyc < 1100) begin
      tick();
      cyc++;
    end
    check("init_done_cycle", 64'(cyc), 64'd1025);
    check("init_wr_count", 64'(init_wr_cnt), 64'd1024);
    check("init_seq_err", 64'(init_err), 64'd0);
    check("init_idle", 64'({bus.o_ram_wr, bus.o_cfg_busy}), 64'd0);
    tick();
    check("init_done_pulse", 64'(bus.o_init_done), 64'd0);
    repeat (3) tick();
    check("init_no_wrap", 64'(init_wr_cnt), 64'd1024);
    check("init_done_once", 64'(done_cnt - base), 64'd1);
    init_mon = 1'b0;
    do_read(10'h3FF, 8'hFF, "rd3ff");
    do_read(10'h005, 8'hFF, "rd005_post");

    // Reset in the middle of an init sweep
    bus.i_init_start = 1'b1; bus.iv_init_data = 8'h5A;
    tick();
    bus.i_init_start = 1'b0;
    cyc = 0;
    while (!(bus.o_ram_wr && bus.ov_ram_addr == 10'h200) && cyc < 700) begin
      tick();
      cyc++;
    end
    check("init_reach_200", 64'({bus.o_ram_wr, bus.ov_ram_addr}), 64'({1'b1, 10'h200}));
    base = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", outs(), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    cyc = wr_cnt;
    repeat (1030) tick();
    check("rst_no_done", 64'(done_cnt - base), 64'd0);
    check("rst_no_writes", 64'(wr_cnt - cyc), 64'd0);
    check("rst_idle_outputs", outs(), 64'd0);
    bus.i_cfg_wr = 1'b1; bus.iv_cfg_addr = 10'h123; bus.iv_cfg_wdata = 8'hC3;
    tick();
    bus.i_cfg_wr = 1'b0;
    check("rst_new_wr", 64'({bus.o_ram_wr, bus.ov_ram_addr, bus.ov_ram_wdata, bus.ov_drop_cnt}),
          64'({1'b1, 10'h123, 8'hC3, 8'h00}));
    tick();

    // Drop counter saturation while an init is running
    bus.i_init_start = 1'b1; bus.iv_init_data = 8'h0F;
    tick();
    bus.i_cfg_wr = 1'b1; bus.i_cfg_rd = 1'b1;
    repeat (50) tick();
    check("drop_150", 64'(bus.ov_drop_cnt), 64'h96);
    repeat (50) tick();
    check("drop_sat", 64'(bus.ov_drop_cnt), 64'hFF);
    bus.i_cfg_wr = 1'b0; bus.i_cfg_rd = 1'b0; bus.i_init_start = 1'b0;
    base = done_cnt;
    cyc = 0;
    while (!bus.o_init_done && cyc < 1100) begin
      tick();
      cyc++;
    end
    check("sat_init_done", 64'(bus.o_init_done), 64'd1);
    check("drop_sat_hold", 64'(bus.ov_drop_cnt), 64'hFF);
    do_read(10'h2AA, 8'h0F, "rd2aa");

    check("no_wr_rd_overlap", 64'(both_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
